// File: rtl/vtisa_pkg.sv
// Shared ISA definitions: opcode encodings and execution-unit state type.
package vtisa_pkg;

    localparam logic [4:0] OP_LI   = 5'd0;
    localparam logic [4:0] OP_ADDI = 5'd1;
    localparam logic [4:0] OP_ADD  = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_SHR  = 5'd8;
    localparam logic [4:0] OP_LD   = 5'd9;
    localparam logic [4:0] OP_ST   = 5'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        MEM  = 2'd2
    } state_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: result, carry/borrow and zero for the register-class opcodes.
module exec_alu
    import vtisa_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMM_W  = 3
) (
    input  logic [4:0]        opcode,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic              is_alu
);

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W:0]   sum_imm;
    logic [DATA_W:0]   sum_reg;
    logic [DATA_W:0]   diff;

    assign imm_ext = DATA_W'(imm);
    assign sum_imm = {1'b0, acc} + {1'b0, imm_ext};
    assign sum_reg = {1'b0, acc} + {1'b0, reg_data};
    // Top bit of the widened difference is the unsigned borrow (acc < reg_data).
    assign diff    = {1'b0, acc} - {1'b0, reg_data};

    // Opcode decode and result/flag selection.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        is_alu = 1'b1;
        case (opcode)
            OP_LI:   result = imm_ext;
            OP_ADDI: {carry, result} = sum_imm;
            OP_ADD:  {carry, result} = sum_reg;
            OP_SUB:  {carry, result} = diff;
            OP_AND:  result = acc & reg_data;
            OP_OR:   result = acc | reg_data;
            OP_XOR:  result = acc ^ reg_data;
            OP_SHL: begin
                result = {acc[DATA_W-2:0], 1'b0};
                carry  = acc[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, acc[DATA_W-1:1]};
                carry  = acc[0];
            end
            default: is_alu = 1'b0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/exec_unit.sv
// Execution unit: runs ALU ops in one writeback cycle, LD/ST through a
// req/ack memory handshake with timeout, flags illegal opcodes as errors.
module exec_unit
    import vtisa_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int IMM_W       = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [4:0]        opcode,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [DATA_W-1:0] acc,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              acc_we,
    output logic [DATA_W-1:0] new_acc,
    output logic              carry,
    output logic              zero,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              is_ld;
    logic [DATA_W-1:0] acc_q;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;
    logic              alu_valid;

    // The ALU sees the operands on the accepting edge; its result is latched
    // there, which equals computing from captured operands one cycle later.
    exec_alu #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_alu (
        .opcode   (opcode),
        .imm      (imm),
        .reg_data (reg_data),
        .acc      (acc),
        .result   (alu_result),
        .carry    (alu_carry),
        .zero     (alu_zero),
        .is_alu   (alu_valid)
    );

    assign instr_ready = (state == IDLE);
    assign mem_addr    = (state == MEM) ? ADDR_W'(acc_q) : pc;

    // Control FSM with registered handshake, writeback and flag outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            is_ld     <= 1'b0;
            acc_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            acc_we    <= 1'b0;
            new_acc   <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    acc_we <= 1'b0;
                    done   <= 1'b0;
                    err    <= 1'b0;
                    if (instr_valid) begin
                        acc_q <= acc;
                        cnt   <= '0;
                        if (opcode == OP_LD || opcode == OP_ST) begin
                            state   <= MEM;
                            mem_req <= 1'b1;
                            mem_we  <= (opcode == OP_ST);
                            is_ld   <= (opcode == OP_LD);
                            if (opcode == OP_ST)
                                mem_wdata <= reg_data;
                        end else if (alu_valid) begin
                            state   <= WB;
                            acc_we  <= 1'b1;
                            done    <= 1'b1;
                            new_acc <= alu_result;
                            carry   <= alu_carry;
                            zero    <= alu_zero;
                        end else begin
                            state <= WB;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                WB: begin
                    acc_we <= 1'b0;
                    done   <= 1'b0;
                    err    <= 1'b0;
                    state  <= IDLE;
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        state   <= WB;
                        if (is_ld) begin
                            acc_we  <= 1'b1;
                            new_acc <= mem_rdata;
                            zero    <= (mem_rdata == '0);
                        end
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        state   <= WB;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed, table-driven bench for exec_unit (8-bit and 16-bit instances).
module tb_exec_unit;
    import vtisa_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 8-bit instance signals
    logic       instr_valid = 1'b0, instr_ready;
    logic [4:0] opcode = '0;
    logic [2:0] imm = '0;
    logic [7:0] reg_data = '0, acc = '0, pc = 8'h12;
    logic       mem_req, mem_we, mem_ack = 1'b0;
    logic [7:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic       acc_we, carry, zero, done, err;
    logic [7:0] new_acc;

    // 16-bit instance signals
    logic        v16 = 1'b0, rdy16;
    logic [4:0]  op16 = '0;
    logic [2:0]  imm16 = '0;
    logic [15:0] reg16 = '0, acc16 = '0, rdata16 = '0;
    logic [7:0]  pc16 = '0, addr16;
    logic        req16, we16, ack16 = 1'b0;
    logic [15:0] wdata16, nacc16;
    logic        awe16, c16, z16, d16, e16;

    exec_unit #(.DATA_W(8), .ADDR_W(8), .IMM_W(3), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .imm(imm), .reg_data(reg_data), .acc(acc), .pc(pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .acc_we(acc_we), .new_acc(new_acc),
        .carry(carry), .zero(zero), .done(done), .err(err)
    );

    exec_unit #(.DATA_W(16), .ADDR_W(8), .IMM_W(3), .MEM_TIMEOUT(15)) dut16 (
        .clk(clk), .reset(reset), .instr_valid(v16), .instr_ready(rdy16),
        .opcode(op16), .imm(imm16), .reg_data(reg16), .acc(acc16), .pc(pc16),
        .mem_req(req16), .mem_we(we16), .mem_addr(addr16), .mem_wdata(wdata16),
        .mem_rdata(rdata16), .mem_ack(ack16), .acc_we(awe16), .new_acc(nacc16),
        .carry(c16), .zero(z16), .done(d16), .err(e16)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one instruction on the 8-bit unit; returns at posedge+1 after acceptance.
    task automatic issue(input logic [4:0] op, input logic [2:0] im,
                         input logic [7:0] rd, input logic [7:0] ac);
        @(negedge clk);
        opcode = op; imm = im; reg_data = rd; acc = ac; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    typedef struct {
        logic [4:0] op;
        logic [2:0] im;
        logic [7:0] rd;
        logic [7:0] ac;
        logic [7:0] e_acc;
        logic       e_c;
        logic       e_z;
        logic       e_we;
        logic       e_err;
    } vec_t;

    vec_t vecs[15];
    int   mcnt;

    initial begin
        vecs[0]  = '{OP_ADDI, 3'd1, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{OP_SUB,  3'd0, 8'h05, 8'h03, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{OP_LI,   3'd7, 8'h00, 8'h00, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{OP_ADD,  3'd0, 8'h20, 8'hF0, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{OP_ADD,  3'd0, 8'h20, 8'h10, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{OP_SUB,  3'd0, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{OP_AND,  3'd0, 8'h0F, 8'hAA, 8'h0A, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{OP_OR,   3'd0, 8'h05, 8'hA0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{OP_XOR,  3'd0, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        // Illegal: new_acc and flags keep the XOR results.
        vecs[9]  = '{5'd31,   3'd0, 8'h11, 8'h22, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{OP_SHL,  3'd0, 8'h00, 8'h81, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{5'd15,   3'd0, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{OP_SHR,  3'd0, 8'h00, 8'h81, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{OP_SHR,  3'd0, 8'h00, 8'h02, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{OP_ADDI, 3'd5, 8'h00, 8'h10, 8'h15, 1'b0, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;

        // Reset state
        #1;
        check("rst_ready", instr_ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_acc_we", acc_we, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_new_acc", new_acc, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_flags", {carry, zero}, 0);
        check("idle_addr_pc", mem_addr, 8'h12);

        // ALU / illegal vector table
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].im, vecs[i].rd, vecs[i].ac);
            check($sformatf("v%0d_done", i), done, 1);
            check($sformatf("v%0d_we", i), acc_we, vecs[i].e_we);
            check($sformatf("v%0d_err", i), err, vecs[i].e_err);
            check($sformatf("v%0d_acc", i), new_acc, vecs[i].e_acc);
            check($sformatf("v%0d_carry", i), carry, vecs[i].e_c);
            check($sformatf("v%0d_zero", i), zero, vecs[i].e_z);
            check($sformatf("v%0d_req", i), mem_req, 0);
            check($sformatf("v%0d_wb_ready", i), instr_ready, 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_drop", i), done, 0);
            check($sformatf("v%0d_we_drop", i), acc_we, 0);
            check($sformatf("v%0d_err_drop", i), err, 0);
            check($sformatf("v%0d_ready", i), instr_ready, 1);
        end

        // LD with ack on third MEM cycle; carry (0) must stay, zero from data
        issue(OP_LD, 3'd0, 8'h00, 8'h40);
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("ld_req_c%0d", c), mem_req, 1);
            check($sformatf("ld_addr_c%0d", c), mem_addr, 8'h40);
            check($sformatf("ld_we_c%0d", c), mem_we, 0);
            check($sformatf("ld_nodone_c%0d", c), done, 0);
            if (c == 3) begin
                @(negedge clk); mem_ack = 1'b1; mem_rdata = 8'h5A;
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        check("ld_done", done, 1);
        check("ld_we", acc_we, 1);
        check("ld_err", err, 0);
        check("ld_acc", new_acc, 8'h5A);
        check("ld_carry", carry, 0);
        check("ld_zero", zero, 0);
        check("ld_req_drop", mem_req, 0);
        check("ld_wb_addr_pc", mem_addr, 8'h12);
        @(posedge clk); #1;

        // Stray ack in IDLE must not start anything
        @(negedge clk); mem_ack = 1'b1;
        @(posedge clk); #1; mem_ack = 1'b0;
        check("stray_ack_done", done, 0);
        check("stray_ack_ready", instr_ready, 1);

        // ST with no ack: timeout after 15 request cycles
        issue(OP_ST, 3'd0, 8'h33, 8'h80);
        check("st_we", mem_we, 1);
        check("st_wdata", mem_wdata, 8'h33);
        check("st_addr", mem_addr, 8'h80);
        mcnt = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (mem_req) mcnt++;
            @(posedge clk); #1;
        end
        check("st_to_cycles", mcnt, 15);
        check("st_to_done", done, 1);
        check("st_to_err", err, 1);
        check("st_to_we", acc_we, 0);
        check("st_to_req", mem_req, 0);
        check("st_to_acc_hold", new_acc, 8'h5A);
        @(posedge clk); #1;
        check("st_to_err_drop", err, 0);

        // ST with ack on the 15th cycle: ack wins over timeout
        issue(OP_ST, 3'd0, 8'h44, 8'h81);
        for (int c = 1; c <= 15; c++) begin
            check($sformatf("st_ack_req_c%0d", c), mem_req, 1);
            if (c == 15) begin
                @(negedge clk); mem_ack = 1'b1;
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        check("st_ack_done", done, 1);
        check("st_ack_err", err, 0);
        check("st_ack_we", acc_we, 0);
        @(posedge clk); #1;

        // Reset two cycles into an LD wait
        issue(OP_LD, 3'd0, 8'h00, 8'h50);
        @(posedge clk); #1;
        check("rst_mid_req_before", mem_req, 1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_ready", instr_ready, 1);
        check("rst_mid_we", acc_we, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_no_done", done, 0);
        check("rst_mid_no_we", acc_we, 0);

        // 16-bit instance: ADDI wraps to zero with carry
        @(negedge clk);
        op16 = OP_ADDI; imm16 = 3'd1; acc16 = 16'hFFFF; v16 = 1'b1;
        @(posedge clk); #1; v16 = 1'b0;
        check("w16_done", d16, 1);
        check("w16_we", awe16, 1);
        check("w16_acc", nacc16, 16'h0000);
        check("w16_carry", c16, 1);
        check("w16_zero", z16, 1);
        @(posedge clk); #1;
        check("w16_done_drop", d16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, accumulator/operand/memory data width (>=4).
REQ-002 SHALL have parameter ADDR_W, default 8, program-counter and memory address width.
REQ-003 SHALL have parameter IMM_W, default 3, immediate field width (< DATA_W).
REQ-004 SHALL have parameter MEM_TIMEOUT, default 15, max cycles mem_req waits for mem_ack (>=1).
REQ-005 SHALL have ports: clk input 1 clock; reset input 1 (reset, synchronous, active-high).
REQ-006 SHALL have ports: instr_valid input 1 decoded instruction present; instr_ready output 1 unit can accept.
REQ-007 SHALL have ports: opcode input 5; imm input IMM_W; reg_data input DATA_W selected register value; acc input DATA_W; pc input ADDR_W.
REQ-008 SHALL have ports: mem_req output 1; mem_we output 1; mem_addr output ADDR_W; mem_wdata output DATA_W; mem_rdata input DATA_W; mem_ack input 1.
REQ-009 SHALL have ports: acc_we output 1; new_acc output DATA_W; carry output 1; zero output 1; done output 1; err output 1.

Function
REQ-010 SHALL implement states IDLE, WB, MEM, in that encoding order; IDLE after reset.
REQ-011 SHALL drive instr_ready=1 only in IDLE; instruction accepted on clk edge with instr_valid & instr_ready; all operands (opcode, imm, reg_data, acc) captured at acceptance.
REQ-012 SHALL drive mem_addr = pc in IDLE/WB and = captured acc in MEM.
REQ-013 SHALL compute ALU ops from captured operands: LI zext(imm); ADDI acc+zext(imm); ADD acc+reg; SUB acc-reg; AND/OR/XOR bitwise with reg; SHL acc<<1; SHR acc>>1 (logical); results truncated to DATA_W.
REQ-014 SHALL set carry: ADDI/ADD carry-out of DATA_W-bit add; SUB borrow (1 when acc<reg, unsigned); SHL old msb; SHR old lsb; LI/AND/OR/XOR carry=0.
REQ-015 SHALL set zero = (result == 0) for every ALU op and LD; ST and illegal ops leave carry and zero unchanged; LD leaves carry unchanged.
REQ-016 ALU op accepted: SHALL move IDLE->WB; in WB assert acc_we=1, done=1, new_acc=result, flags updated, for exactly one cycle, then WB->IDLE (accept-to-done latency 1 cycle, throughput 1 instr/2 cycles).
REQ-017 LD/ST accepted: SHALL move IDLE->MEM, assert mem_req=1 and hold mem_addr, mem_we, mem_wdata stable until mem_ack sampled high.
REQ-018 ST: mem_we=1, mem_wdata=captured reg_data; on mem_ack SHALL go to WB with acc_we=0, done=1.
REQ-019 LD: mem_we=0; on mem_ack SHALL register mem_rdata into new_acc, go to WB with acc_we=1, done=1.
REQ-020 SHALL count MEM cycles without ack; if mem_ack still low on the MEM_TIMEOUT-th cycle, deassert mem_req, go to WB with done=1, err=1, acc_we=0; mem_ack on that same cycle wins (normal completion).
REQ-021 Opcodes outside package set: SHALL go to WB with done=1, err=1, acc_we=0, no memory access.
REQ-022 err SHALL be valid only while done=1 and 0 otherwise; mem_ack outside MEM SHALL be ignored.
REQ-023 new_acc SHALL hold its last value when acc_we=0.

Reset
REQ-024 On reset SHALL force state IDLE, timeout counter 0, mem_req=0, mem_we=0, acc_we=0, done=0, err=0, carry=0, zero=0, new_acc=0, mem_wdata=0.
REQ-025 Reset asserted mid-MEM SHALL drop mem_req at that clock edge; the aborted instruction SHALL produce no done and no writeback.

Structure
REQ-026 SHALL place opcode constants (OP_LI=0, OP_ADDI=1, OP_ADD=2, OP_SUB=3, OP_AND=4, OP_OR=5, OP_XOR=6, OP_SHL=7, OP_SHR=8, OP_LD=9, OP_ST=10) and the state enum in shared package vtisa_pkg.
REQ-027 SHALL place ALU datapath (REQ-013..015) in combinational sub-module exec_alu, parametrised by DATA_W and IMM_W.

Verification
REQ-028 DATA_W=8: acc=0xFF, ADDI imm=1 -> one cycle later acc_we=1, done=1, new_acc=0x00, carry=1, zero=1.
REQ-029 SUB acc=0x03 reg=0x05 -> new_acc=0xFE, carry=1, zero=0; LI imm=7 after -> new_acc=0x07, carry=0.
REQ-030 LD acc=0x40, mem_ack after 3 cycles with rdata=0x5A -> mem_req high 3 cycles, mem_addr=0x40, then done with new_acc=0x5A.
REQ-031 ST reg=0x33, no mem_ack, MEM_TIMEOUT=15 -> mem_req high 15 cycles then done=1, err=1, acc_we=0; opcode 31 -> done=1, err=1, mem_req never high.
REQ-032 Reset asserted 2 cycles into LD wait -> mem_req=0, done=0 next cycle, instr_ready=1; repeat REQ-028 with DATA_W=16 (acc=0xFFFF) -> new_acc=0x0000, carry=1.
